shift_reg_param_burst: RTL



---
 rtl/shift_reg_param_burst_pkg.sv | 22 ++
 rtl/shift_reg_param_burst_if.sv | 47 ++++
 rtl/shift_reg_param_burst_shift_slice.sv | 50 +++++
 rtl/shift_reg_param_burst.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/shift_reg_param_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module  : shift_reg_param_burst_pkg
// Brief   : Shared mode, direction and FSM-state constants for the burst
//           shift register slice of the codebase.
// Revision: 1.0
// ============================================================================
package shift_reg_param_burst_pkg;

    localparam logic [1:0] MODE_SHIFT = 2'b00;
    localparam logic [1:0] MODE_ROT   = 2'b01;
    localparam logic [1:0] MODE_LOAD  = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_BURST   = 1'b1;

    localparam logic       DIR_UP     = 1'b0;
    localparam logic       DIR_DN     = 1'b1;

endpackage
`default_nettype wire

// File: rtl/shift_reg_param_burst_if.sv
`default_nettype none
// ============================================================================
// Module  : shift_reg_param_burst_if
// Brief   : Control/data bundle of the burst shift register. The ARITH_SHIFT_EN
//           macro adds the arith request line.
// Revision: 1.0
// ============================================================================
interface shift_reg_param_burst_if #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4,
    parameter int CW    = 6
);
    localparam int c_nslice = WIDTH / SLICE;

    logic                enb;
    logic [1:0]          modo;
    logic                dir;
    logic                s_in;
    logic [WIDTH-1:0]    d;
    logic                start;
    logic [CW-1:0]       count;
`ifdef ARITH_SHIFT_EN
    logic                arith;
`endif
    logic [WIDTH-1:0]    q;
    logic [c_nslice-1:0] s_out;
    logic                busy;
    logic                done;

    modport master (
        output enb, modo, dir, s_in, d, start, count,
`ifdef ARITH_SHIFT_EN
        output arith,
`endif
        input  q, s_out, busy, done
    );

    modport slave (
        input  enb, modo, dir, s_in, d, start, count,
`ifdef ARITH_SHIFT_EN
        input  arith,
`endif
        output q, s_out, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/shift_reg_param_burst_shift_slice.sv
`default_nettype none
// ============================================================================
// Module  : shift_slice
// Brief   : SLICE-bit register with serial in, bidirectional single-step
//           shift, parallel load and hold.
// Revision: 1.0
// ============================================================================
module shift_slice
    import shift_reg_param_burst_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_step,
    input  wire logic             i_dir,
    input  wire logic             i_ser_in,
    input  wire logic [SLICE-1:0] i_d,
    output logic      [SLICE-1:0] o_q
);

    logic [SLICE-1:0] r_q;
    logic [SLICE-1:0] w_up;
    logic [SLICE-1:0] w_dn;

    generate
        if (SLICE == 1) begin : g_single
            assign w_up = i_ser_in;
            assign w_dn = i_ser_in;
        end else begin : g_multi
            assign w_up = {r_q[SLICE-2:0], i_ser_in};
            assign w_dn = {i_ser_in, r_q[SLICE-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_step) begin
            r_q <= (i_dir == DIR_DN) ? w_dn : w_up;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/shift_reg_param_burst.sv
`default_nettype none
// ============================================================================
// Module  : shift_reg_param_burst
// Brief   : WIDTH-bit sliced shift/rotate/load register with a counted burst
//           engine. Optional macro ARITH_SHIFT_EN enables sign-fill shifts.
// Revision: 1.0
// ============================================================================
module shift_reg_param_burst
    import shift_reg_param_burst_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4,
    parameter int CW    = 6
) (
    input  wire logic              clk,
    input  wire logic              rst,
    shift_reg_param_burst_if.slave bus
);

    localparam int c_nslice = WIDTH / SLICE;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic             r_dir;
    logic             r_done;

    logic             w_busy;
    logic             w_accept;
    logic [1:0]       w_eff_mode;
    logic             w_eff_dir;
    logic             w_eff_arith;
    logic             w_step;
    logic             w_load;
    logic             w_fill_lo;
    logic             w_fill_hi;
    logic [WIDTH-1:0] w_q;

    assign w_busy   = (r_state == ST_BURST);
    assign w_accept = bus.enb && !w_busy && bus.start && !bus.modo[1];

    // During a burst the latched op/direction drive the datapath and taps.
    assign w_eff_mode = w_busy ? {1'b0, r_op} : bus.modo;
    assign w_eff_dir  = w_busy ? r_dir : bus.dir;

`ifdef ARITH_SHIFT_EN
    logic r_arith;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arith <= 1'b0;
        end else if (w_accept) begin
            r_arith <= bus.arith;
        end
    end

    assign w_eff_arith = w_busy ? r_arith : bus.arith;
`else
    assign w_eff_arith = 1'b0;
`endif

    // The acceptance edge itself leaves Q untouched.
    assign w_step = bus.enb && (w_busy ||
                    (!w_accept && (bus.modo == MODE_SHIFT || bus.modo == MODE_ROT)));
    assign w_load = bus.enb && !w_busy && (bus.modo == MODE_LOAD);

    assign w_fill_lo = (w_eff_mode == MODE_ROT) ? w_q[WIDTH-1] : bus.s_in;
    assign w_fill_hi = (w_eff_mode == MODE_ROT) ? w_q[0] :
                       (w_eff_arith ? w_q[WIDTH-1] : bus.s_in);

    generate
        for (genvar k = 0; k < c_nslice; k++) begin : g_slice
            logic w_from_below;
            logic w_from_above;
            logic w_ser;

            if (k == 0) begin : g_lo_end
                assign w_from_below = w_fill_lo;
            end else begin : g_lo_chain
                assign w_from_below = w_q[k*SLICE-1];
            end

            if (k == c_nslice - 1) begin : g_hi_end
                assign w_from_above = w_fill_hi;
            end else begin : g_hi_chain
                assign w_from_above = w_q[(k+1)*SLICE];
            end

            assign w_ser = (w_eff_dir == DIR_DN) ? w_from_above : w_from_below;

            shift_slice #(
                .SLICE (SLICE)
            ) u_slice (
                .clk      (clk),
                .rst      (rst),
                .i_load   (w_load),
                .i_step   (w_step),
                .i_dir    (w_eff_dir),
                .i_ser_in (w_ser),
                .i_d      (bus.d[k*SLICE +: SLICE]),
                .o_q      (w_q[k*SLICE +: SLICE])
            );

            assign bus.s_out[k] = (w_eff_mode != MODE_SHIFT) ? 1'b0 :
                                  (w_eff_dir == DIR_DN) ? w_q[k*SLICE]
                                                        : w_q[k*SLICE+SLICE-1];
        end
    endgenerate

    // DONE is cleared on every edge; ENB only gates state and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_dir   <= DIR_UP;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_op  <= bus.modo[0];
                r_dir <= bus.dir;
                r_cnt <= bus.count;
                if (bus.count == '0) begin
                    r_done <= 1'b1;
                end else begin
                    r_state <= ST_BURST;
                end
            end else if (bus.enb && w_busy) begin
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.q    = w_q;
    assign bus.busy = w_busy;
    assign bus.done = r_done;

endmodule
`default_nettype wire
